instructie_prefetch: RTL and testbench

- Fetch stage upstream of the instruction decoder.
- Drives the synchronous program ROM address and absorbs the ROM's 1-cycle read latency.
- Buffers fetched 40-bit instructions (opcode[39:32], arg1[31:16], arg2[15:0]) in a small FIFO and hands them to the decoder over a valid/ready handshake.
- Redirects and flushes on jump requests from the execute side; the jump opcode is 0x09.

---
 rtl/instructie_prefetch.sv | 184 ++++++++++++++++++
 tb/tb_instructie_prefetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/instructie_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : instructie_prefetch
// Purpose  : Instruction fetch stage. It drives the synchronous program ROM
//            address and absorbs the ROM's one-cycle read latency. Fetched
//            words go into a small FIFO, and the decoder drains that FIFO
//            over a valid/ready handshake. A jump request flushes the FIFO
//            and redirects fetching.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock        in   system clock, rising edge
//   reset_n      in   synchronous reset, active-low
//   rom_addr     out  registered fetch address to program_rom
//   rom_data     in   ROM word, one cycle after rom_addr was sampled
//   ins_valid    out  FIFO head holds an instruction
//   ins_ready    in   decoder accepts the head at this edge
//   ins_data     out  head instruction word (0 when empty)
//   ins_pc       out  fetch address of the head word (0 when empty)
//   jump_valid   in   redirect request (flushes, highest priority)
//   jump_target  in   new fetch address
//   fetch_count  out  issue counter (saturating)
//   flush_count  out  jump counter (saturating)
// Configuration
//   PREFETCH_PERF_EN : builds the fetch/flush counters. When it is undefined,
//                      both counter ports are tied to zero.
// ============================================================================
module instructie_prefetch #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 40,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_data,
  output logic               ins_valid,
  input  logic               ins_ready,
  output logic [INSTR_W-1:0] ins_data,
  output logic [ADDR_W-1:0]  ins_pc,
  input  logic               jump_valid,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic [15:0]        fetch_count,
  output logic [15:0]        flush_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] C_DEPTH = (CNT_W + 1)'(DEPTH);

  // Fetch-side state
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_epoch_q, inflight_epoch_d;
  logic              epoch_q, epoch_d;

  // FIFO state
  logic [INSTR_W-1:0] data_mem_q [DEPTH];
  logic [ADDR_W-1:0]  pc_mem_q   [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic           issue;
  logic           push;
  logic           pop;
  logic [CNT_W:0] occupancy;

  // An in-flight fetch already owns a FIFO slot. Occupancy is taken before
  // any pop at this edge, so a simultaneous pop does not free a slot early.
  assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign issue     = !jump_valid && (occupancy < C_DEPTH);

  // The captured word is kept only if no jump happened since it was issued.
  // A jump at this very edge flushes everything, including this word.
  assign push = inflight_q && (inflight_epoch_q == epoch_q) && !jump_valid;

  // A pop at a jump edge is squashed together with the rest of the FIFO.
  assign pop  = ins_valid && ins_ready && !jump_valid;

  always_comb begin
    fetch_pc_d       = fetch_pc_q;
    inflight_d       = issue;
    inflight_pc_d    = inflight_pc_q;
    inflight_epoch_d = inflight_epoch_q;
    epoch_d          = epoch_q ^ jump_valid;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;

    if (jump_valid) begin
      fetch_pc_d = jump_target;
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
    end

    if (issue) begin
      inflight_pc_d    = fetch_pc_q;
      inflight_epoch_d = epoch_q;
    end

    if (jump_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fetch_pc_q       <= RESET_PC;
      inflight_q       <= 1'b0;
      inflight_pc_q    <= '0;
      inflight_epoch_q <= 1'b0;
      epoch_q          <= 1'b0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
    end else begin
      fetch_pc_q       <= fetch_pc_d;
      inflight_q       <= inflight_d;
      inflight_pc_q    <= inflight_pc_d;
      inflight_epoch_q <= inflight_epoch_d;
      epoch_q          <= epoch_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
    end
  end

  // Storage needs no reset: the output mux hides entries that are not valid.
  always_ff @(posedge clock) begin
    if (reset_n && push) begin
      data_mem_q[wr_ptr_q] <= rom_data;
      pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

  assign rom_addr  = fetch_pc_q;
  assign ins_valid = (count_q != '0);
  assign ins_data  = ins_valid ? data_mem_q[rd_ptr_q] : '0;
  assign ins_pc    = ins_valid ? pc_mem_q[rd_ptr_q]   : '0;

`ifdef PREFETCH_PERF_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] flush_cnt_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (issue && (fetch_cnt_q != 16'hFFFF)) begin
        fetch_cnt_q <= fetch_cnt_q + 16'd1;
      end
      if (jump_valid && (flush_cnt_q != 16'hFFFF)) begin
        flush_cnt_q <= flush_cnt_q + 16'd1;
      end
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  assign fetch_count = 16'h0000;
  assign flush_count = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instructie_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instructie_prefetch
// Purpose  : Directed self-checking bench for instructie_prefetch. The ROM
//            model returns word[n] = {8'h01, n, ~n} one cycle after sampling
//            the address.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instructie_prefetch;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] rom_addr;
  logic [39:0] rom_data;
  logic        ins_valid;
  logic        ins_ready;
  logic [39:0] ins_data;
  logic [15:0] ins_pc;
  logic        jump_valid;
  logic [15:0] jump_target;
  logic [15:0] fetch_count;
  logic [15:0] flush_count;

  int n_vec = 0;
  int n_bad = 0;

  instructie_prefetch dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .ins_data    (ins_data),
    .ins_pc      (ins_pc),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .fetch_count (fetch_count),
    .flush_count (flush_count)
  );

  always #5 clock = ~clock;

  function automatic logic [39:0] word(input logic [15:0] n);
    return {8'h01, n, ~n};
  endfunction

  // Synchronous ROM: the address is sampled at the edge, the data appears after it
  always @(posedge clock) rom_data <= word(rom_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [15:0] pc);
    chk({tag, ".valid"}, ins_valid, 1'b1);
    chk({tag, ".pc"}, ins_pc, pc);
    chk({tag, ".data"}, ins_data, word(pc));
  endtask

  logic [15:0] exp_fetch4;
  logic [15:0] exp_flush1;

  initial begin
`ifdef PREFETCH_PERF_EN
    exp_fetch4 = 16'd4;
    exp_flush1 = 16'd1;
`else
    exp_fetch4 = 16'd0;
    exp_flush1 = 16'd0;
`endif
    reset_n     = 1'b0;
    ins_ready   = 1'b1;
    jump_valid  = 1'b0;
    jump_target = 16'h0000;

    // ---- Reset state ----
    tick();
    tick();
    chk("rst.valid", ins_valid, 1'b0);
    chk("rst.data", ins_data, 40'h0);
    chk("rst.pc", ins_pc, 16'h0);
    chk("rst.rom_addr", rom_addr, 16'h0000);
    chk("rst.fetch_count", fetch_count, 16'h0);
    chk("rst.flush_count", flush_count, 16'h0);

    // ---- Latency and streaming at one word per cycle ----
    reset_n = 1'b1;
    tick();                                   // E1: issue pc 0
    chk("lat.e1.valid", ins_valid, 1'b0);
    chk("lat.e1.rom_addr", rom_addr, 16'h0001);
    tick();                                   // E2: pc 0 captured
    chk_head("lat.e2", 16'h0000);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_head("stream", 16'(i));
    end
    // pc 5 is the head now. Pop it, then jump while pc 7 is in flight.
    tick();
    chk_head("prejump", 16'h0006);
    jump_valid  = 1'b1;
    jump_target = 16'h0020;
    tick();
    jump_valid = 1'b0;
    chk("jmp.flushed", ins_valid, 1'b0);
    chk("jmp.rom_addr", rom_addr, 16'h0020);
    tick();
    chk("jmp.e1.valid", ins_valid, 1'b0);
    tick();
    chk_head("jmp.e2", 16'h0020);
    tick();
    chk_head("jmp.e3", 16'h0021);

    // ---- Back-pressure from reset: four words buffered, then drained ----
    reset_n   = 1'b0;
    ins_ready = 1'b0;
    tick();
    chk("bp.rst.flush_count", flush_count, 16'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk_head("bp.full", 16'h0000);
    chk("bp.rom_addr", rom_addr, 16'h0004);
    chk("bp.fetch_count", fetch_count, exp_fetch4);
    ins_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("bp.drain.pc", ins_pc, 16'(i));
      chk("bp.drain.valid", ins_valid, 1'b1);
      tick();
    end

    // ---- Jump across the address wrap ----
    jump_valid  = 1'b1;
    jump_target = 16'hFFFE;
    tick();
    jump_valid = 1'b0;
    chk("wrap.flush_count", flush_count, exp_flush1);
    tick();
    tick();
    chk_head("wrap.0", 16'hFFFE);
    tick();
    chk_head("wrap.1", 16'hFFFF);
    tick();
    chk_head("wrap.2", 16'h0000);
    tick();
    chk_head("wrap.3", 16'h0001);

    // ---- Jump at the same edge as a pop: the head is squashed ----
    jump_valid  = 1'b1;
    jump_target = 16'h0100;
    tick();
    jump_valid = 1'b0;
    chk("sq.empty", ins_valid, 1'b0);
    chk("sq.pc", ins_pc, 16'h0);
    tick();
    chk("sq.e1.valid", ins_valid, 1'b0);
    tick();
    chk_head("sq.e2", 16'h0100);
    tick();
    chk_head("sq.e3", 16'h0101);

    // ---- Reset while the FIFO is half full and a fetch is in flight ----
    jump_valid  = 1'b1;
    jump_target = 16'h0200;
    ins_ready   = 1'b0;
    tick();
    jump_valid = 1'b0;
    tick();                                   // issue 0x200
    tick();                                   // push 0x200, issue 0x201
    tick();                                   // push 0x201, issue 0x202
    chk_head("mid.half", 16'h0200);
    chk("mid.rom_addr", rom_addr, 16'h0203);
    reset_n = 1'b0;
    tick();
    chk("mid.rst.valid", ins_valid, 1'b0);
    chk("mid.rst.rom_addr", rom_addr, 16'h0000);
    chk("mid.rst.fetch_count", fetch_count, 16'h0);
    reset_n   = 1'b1;
    ins_ready = 1'b1;
    tick();
    chk("mid.e1.valid", ins_valid, 1'b0);
    tick();
    chk_head("mid.e2", 16'h0000);
    tick();
    chk_head("mid.e3", 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
